// File: rtl/minterm_sweep_checker_pkg.sv
// Shared types and constants for the minterm sweep checker: FSM encoding,
// golden truth table for F = m(0,1,8,9,10,11,12,14,15) and datapath widths.
package minterm_sweep_checker_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  // Bit k is the expected function output for input vector k (W=bit3 .. Z=bit0).
  localparam logic [NUM_VEC-1:0] DEFAULT_MINTERM_MASK = 16'hDF03;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

endpackage

// File: rtl/minterm_sweep_checker_if.sv
// Signal bundle between the sweep checker and its environment.
// start is a one-cycle request, honoured only while the checker is IDLE or
// DONE (not busy); a start seen while busy is dropped with no side effects.
interface minterm_sweep_checker_if;
  import minterm_sweep_checker_pkg::*;

  logic                 start;
  logic                 f_in;
  logic [VEC_W-1:0]     vec_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     fail_count;
  logic                 first_fail_valid;
  logic [VEC_W-1:0]     first_fail_idx;
  logic [NUM_VEC-1:0]   observed_mask;
  state_t               dbg_state;

  modport master (
    output start, f_in,
    input  vec_out, busy, done, pass, fail_count,
           first_fail_valid, first_fail_idx, observed_mask, dbg_state
  );

  modport slave (
    input  start, f_in,
    output vec_out, busy, done, pass, fail_count,
           first_fail_valid, first_fail_idx, observed_mask, dbg_state
  );

endinterface

// File: rtl/minterm_sweep_checker_settle_timer.sv
// Clear/enable settle counter; expire is high in the enabled cycle where the
// count has reached SETTLE_CYCLES-1, i.e. after SETTLE_CYCLES enabled cycles.
module minterm_sweep_checker_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expire = en && (cnt == LAST_CNT);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Exhaustive sweep of a 4-input function: drives vectors 0..15, samples f_in
// after a settle time, and records mismatches against the golden mask.
module minterm_sweep_checker
  import minterm_sweep_checker_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] MINTERM_MASK  = DEFAULT_MINTERM_MASK,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  minterm_sweep_checker_if.slave  bus
);

  state_t               state;
  logic [VEC_W-1:0]     idx;
  logic [VEC_W-1:0]     vec_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic [CNT_W-1:0]     fail_count_r;
  logic                 ffv_r;
  logic [VEC_W-1:0]     ffi_r;
  logic [NUM_VEC-1:0]   obs_r;

  logic                 accept_start;
  logic                 mismatch;
  logic [CNT_W-1:0]     fail_next;
  logic                 timer_clr;
  logic                 timer_en;
  logic                 timer_expire;

  assign accept_start = bus.start && ((state == IDLE) || (state == DONE));
  assign mismatch     = (bus.f_in != MINTERM_MASK[idx]);
  assign fail_next    = fail_count_r + {{(CNT_W-1){1'b0}}, mismatch};

  // The timer restarts on every entry into SETTLE: from a start or from a
  // non-final SAMPLE.
  assign timer_clr = accept_start || ((state == SAMPLE) && (idx != LAST_IDX));
  assign timer_en  = (state == SETTLE);

  minterm_sweep_checker_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      vec_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_count_r <= '0;
      ffv_r        <= 1'b0;
      ffi_r        <= '0;
      obs_r        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= SETTLE;
            idx          <= '0;
            vec_r        <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_count_r <= '0;
            ffv_r        <= 1'b0;
            ffi_r        <= '0;
            obs_r        <= '0;
          end
        end

        SETTLE: begin
          if (timer_expire) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          obs_r[idx]   <= bus.f_in;
          fail_count_r <= fail_next;
          if (mismatch && !ffv_r) begin
            ffv_r <= 1'b1;
            ffi_r <= idx;
          end
          if (idx == LAST_IDX) begin
            // pass must reflect this last sample, so it uses fail_next.
            state  <= DONE;
            vec_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (fail_next == '0);
          end else begin
            state <= SETTLE;
            idx   <= idx + 4'd1;
            vec_r <= idx + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out          = vec_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.pass             = pass_r;
  assign bus.fail_count       = fail_count_r;
  assign bus.first_fail_valid = ffv_r;
  assign bus.first_fail_idx   = ffi_r;
  assign bus.observed_mask    = obs_r;
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker: ideal, faulty and stuck function
// models, mid-sweep reset, ignored restart, restart from DONE, SETTLE_CYCLES=1.
module tb_minterm_sweep_checker;
  import minterm_sweep_checker_pkg::*;

  localparam logic [15:0] GOLD = 16'hDF03;

  logic clk;
  logic rst;
  logic start_r;
  logic sel;
  int   mode;
  int   checks;
  int   failures;

  int   trace_vec  [0:200];
  int   trace_busy [0:200];
  int   trace_done [0:200];

  minterm_sweep_checker_if ifc0 ();
  minterm_sweep_checker_if ifc1 ();

  minterm_sweep_checker #(.MINTERM_MASK(16'hDF03), .SETTLE_CYCLES(2)) dut0 (
    .clk (clk), .rst (rst), .bus (ifc0.slave)
  );

  minterm_sweep_checker #(.MINTERM_MASK(16'hDF03), .SETTLE_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst), .bus (ifc1.slave)
  );

  // Function block models: 0 = ideal, 1 = output forced low at vector 12,
  // 2 = output stuck at one.
  function automatic logic f_model(input logic [3:0] v, input int m);
    logic [15:0] g;
    g = GOLD;
    case (m)
      1:       return (v == 4'd12) ? 1'b0 : g[v];
      2:       return 1'b1;
      default: return g[v];
    endcase
  endfunction

  assign ifc0.f_in  = f_model(ifc0.vec_out, mode);
  assign ifc1.f_in  = f_model(ifc1.vec_out, 0);
  assign ifc0.start = start_r & ~sel;
  assign ifc1.start = start_r & sel;

  logic [3:0]  m_vec;
  logic        m_busy, m_done, m_pass, m_ffv;
  logic [4:0]  m_fc;
  logic [3:0]  m_ffi;
  logic [15:0] m_obs;
  state_t      m_state;

  assign m_vec   = sel ? ifc1.vec_out          : ifc0.vec_out;
  assign m_busy  = sel ? ifc1.busy             : ifc0.busy;
  assign m_done  = sel ? ifc1.done             : ifc0.done;
  assign m_pass  = sel ? ifc1.pass             : ifc0.pass;
  assign m_fc    = sel ? ifc1.fail_count       : ifc0.fail_count;
  assign m_ffv   = sel ? ifc1.first_fail_valid : ifc0.first_fail_valid;
  assign m_ffi   = sel ? ifc1.first_fail_idx   : ifc0.first_fail_idx;
  assign m_obs   = sel ? ifc1.observed_mask    : ifc0.observed_mask;
  assign m_state = sel ? ifc1.dbg_state        : ifc0.dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start is presented across exactly one rising edge (edge 0); returns 1
  // time unit after that edge.
  task automatic do_start();
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
  endtask

  // Records outputs after each edge (index = edge number after the start)
  // until done is seen or 200 edges pass; optionally re-pulses start so that
  // it is sampled at edge restart_at.
  task automatic run_sweep(input int restart_at, output int done_edge);
    done_edge = -1;
    for (int e = 0; e <= 200; e++) begin
      if (e > 0) begin
        if (e == restart_at) begin
          @(negedge clk);
          start_r = 1'b1;
        end
        @(posedge clk);
        #1;
        start_r = 1'b0;
      end
      trace_vec[e]  = int'(m_vec);
      trace_busy[e] = int'(m_busy);
      trace_done[e] = int'(m_done);
      if (m_done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (m_state !== IDLE || m_vec !== 4'd0 || m_busy !== 1'b0 || m_done !== 1'b0 ||
        m_pass !== 1'b0 || m_fc !== 5'd0 || m_ffv !== 1'b0 || m_ffi !== 4'd0 ||
        m_obs !== 16'h0) begin
      failures++;
      $display("FAIL reset_values: state=%0d vec=%0d busy=%b done=%b pass=%b fc=%0d ffv=%b ffi=%0d obs=%h, required all zero/IDLE",
               m_state, m_vec, m_busy, m_done, m_pass, m_fc, m_ffv, m_ffi, m_obs);
    end
  endtask

  task automatic test_ideal();
    int de;
    mode = 0;
    do_start();
    run_sweep(-1, de);
    checks++;
    if (de !== 48) begin failures++; $display("FAIL ideal_done_edge: got %0d, required 48", de); end
    checks++;
    if (m_pass !== 1'b1 || m_fc !== 5'd0 || m_ffv !== 1'b0) begin
      failures++;
      $display("FAIL ideal_result: pass=%b fc=%0d ffv=%b, required pass=1 fc=0 ffv=0", m_pass, m_fc, m_ffv);
    end
    checks++;
    if (m_obs !== 16'hDF03) begin failures++; $display("FAIL ideal_observed: got %h, required df03", m_obs); end
    checks++;
    if (trace_vec[0] !== 0 || trace_vec[2] !== 0 || trace_vec[3] !== 1 ||
        trace_vec[13] !== 4 || trace_vec[47] !== 15 || trace_vec[48] !== 0) begin
      failures++;
      $display("FAIL ideal_vec_trace: e0=%0d e2=%0d e3=%0d e13=%0d e47=%0d e48=%0d, required 0 0 1 4 15 0",
               trace_vec[0], trace_vec[2], trace_vec[3], trace_vec[13], trace_vec[47], trace_vec[48]);
    end
    checks++;
    if (trace_busy[0] !== 1 || trace_busy[47] !== 1 || trace_done[47] !== 0 ||
        trace_busy[48] !== 0 || trace_done[48] !== 1) begin
      failures++;
      $display("FAIL ideal_busy_done: busy0=%0d busy47=%0d done47=%0d busy48=%0d done48=%0d, required 1 1 0 0 1",
               trace_busy[0], trace_busy[47], trace_done[47], trace_busy[48], trace_done[48]);
    end
    checks++;
    if (m_state !== DONE) begin failures++; $display("FAIL ideal_state: got %0d, required DONE(3)", m_state); end
  endtask

  task automatic test_force0_at_12();
    int de;
    mode = 1;
    do_start();
    run_sweep(-1, de);
    checks++;
    if (de !== 48) begin failures++; $display("FAIL force0_done_edge: got %0d, required 48", de); end
    checks++;
    if (m_fc !== 5'd1 || m_ffv !== 1'b1 || m_ffi !== 4'd12 || m_pass !== 1'b0) begin
      failures++;
      $display("FAIL force0_result: fc=%0d ffv=%b ffi=%0d pass=%b, required 1 1 12 0", m_fc, m_ffv, m_ffi, m_pass);
    end
    checks++;
    if (m_obs !== 16'hCF03) begin failures++; $display("FAIL force0_observed: got %h, required cf03", m_obs); end
  endtask

  task automatic test_stuck_one();
    int de;
    mode = 2;
    do_start();
    run_sweep(-1, de);
    checks++;
    if (de !== 48) begin failures++; $display("FAIL stuck1_done_edge: got %0d, required 48", de); end
    checks++;
    if (m_fc !== 5'd7 || m_ffv !== 1'b1 || m_ffi !== 4'd2 || m_pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck1_result: fc=%0d ffv=%b ffi=%0d pass=%b, required 7 1 2 0", m_fc, m_ffv, m_ffi, m_pass);
    end
    checks++;
    if (m_obs !== 16'hFFFF) begin failures++; $display("FAIL stuck1_observed: got %h, required ffff", m_obs); end
  endtask

  // Entered from the failing stuck-at-one result, so clearing is observable.
  task automatic test_start_in_done();
    int de;
    mode = 0;
    do_start();
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b1 || m_fc !== 5'd0 || m_ffv !== 1'b0 ||
        m_ffi !== 4'd0 || m_obs !== 16'h0 || m_pass !== 1'b0 || m_vec !== 4'd0) begin
      failures++;
      $display("FAIL restart_clear: done=%b busy=%b fc=%0d ffv=%b ffi=%0d obs=%h pass=%b vec=%0d, required 0 1 0 0 0 0000 0 0",
               m_done, m_busy, m_fc, m_ffv, m_ffi, m_obs, m_pass, m_vec);
    end
    run_sweep(-1, de);
    checks++;
    if (de !== 48 || m_pass !== 1'b1 || m_obs !== 16'hDF03) begin
      failures++;
      $display("FAIL restart_result: done_edge=%0d pass=%b obs=%h, required 48 1 df03", de, m_pass, m_obs);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int de;
    mode = 0;
    do_start();
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_state !== IDLE || m_vec !== 4'd0 || m_busy !== 1'b0 || m_done !== 1'b0 ||
        m_pass !== 1'b0 || m_fc !== 5'd0 || m_ffv !== 1'b0 || m_ffi !== 4'd0 ||
        m_obs !== 16'h0) begin
      failures++;
      $display("FAIL midreset_values: state=%0d vec=%0d busy=%b done=%b pass=%b fc=%0d ffv=%b ffi=%0d obs=%h, required all zero/IDLE",
               m_state, m_vec, m_busy, m_done, m_pass, m_fc, m_ffv, m_ffi, m_obs);
    end
    @(negedge clk);
    rst = 1'b0;
    do_start();
    run_sweep(-1, de);
    checks++;
    if (de !== 48 || m_pass !== 1'b1 || m_fc !== 5'd0) begin
      failures++;
      $display("FAIL midreset_resweep: done_edge=%0d pass=%b fc=%0d, required 48 1 0", de, m_pass, m_fc);
    end
  endtask

  task automatic test_restart_ignored();
    int de;
    mode = 0;
    do_start();
    run_sweep(10, de);
    checks++;
    if (de !== 48) begin failures++; $display("FAIL busy_start_done_edge: got %0d, required 48", de); end
    checks++;
    if (trace_vec[10] !== 3 || trace_vec[11] !== 3 || trace_vec[12] !== 4) begin
      failures++;
      $display("FAIL busy_start_vec: e10=%0d e11=%0d e12=%0d, required 3 3 4",
               trace_vec[10], trace_vec[11], trace_vec[12]);
    end
    checks++;
    if (m_pass !== 1'b1 || m_obs !== 16'hDF03) begin
      failures++;
      $display("FAIL busy_start_result: pass=%b obs=%h, required 1 df03", m_pass, m_obs);
    end
  endtask

  task automatic test_settle_one();
    int de;
    sel = 1'b1;
    #1;
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_state !== IDLE) begin
      failures++;
      $display("FAIL s1_idle: done=%b busy=%b state=%0d, required 0 0 IDLE", m_done, m_busy, m_state);
    end
    do_start();
    run_sweep(-1, de);
    checks++;
    if (de !== 32) begin failures++; $display("FAIL s1_done_edge: got %0d, required 32", de); end
    checks++;
    if (m_pass !== 1'b1 || m_fc !== 5'd0 || m_obs !== 16'hDF03) begin
      failures++;
      $display("FAIL s1_result: pass=%b fc=%0d obs=%h, required 1 0 df03", m_pass, m_fc, m_obs);
    end
    checks++;
    if (trace_vec[1] !== 0 || trace_vec[2] !== 1 || trace_vec[31] !== 15 || trace_vec[32] !== 0) begin
      failures++;
      $display("FAIL s1_vec_trace: e1=%0d e2=%0d e31=%0d e32=%0d, required 0 1 15 0",
               trace_vec[1], trace_vec[2], trace_vec[31], trace_vec[32]);
    end
    sel = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start_r  = 1'b0;
    sel      = 1'b0;
    mode     = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ideal();
    test_force0_at_12();
    test_stuck_one();
    test_start_in_done();
    test_reset_mid_sweep();
    test_restart_ignored();
    test_settle_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minterm_sweep_checker.md
# minterm_sweep_checker

Sequential exhaustive-sweep stage for the 4-input sum-of-minterms function block, F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15).

- Upstream role: drives the function's W/X/Y/Z inputs with all 16 vectors in ascending order.
- Downstream role: samples the function's single-bit output for each vector after a programmable settle time, compares it against a golden minterm mask, and reports pass/fail, mismatch count, first failing index and the captured truth table.
- It turns the combinational block into a self-checking on-chip unit.

## Interface
Parameters:
- MINTERM_MASK, 16'hDF03, golden truth table; bit k = expected F for vector k.
- SETTLE_CYCLES, 2, cycles vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle request; accepted only in IDLE or DONE.
- f_in  input  1  output of the function block under test.
- vec_out  output  4  vector driven to the function; bit3=W, bit2=X, bit1=Y, bit0=Z.
- busy  output  1  high in SETTLE or SAMPLE.
- done  output  1  high in DONE; held until the next accepted start or rst.
- pass  output  1  done && (fail_count == 0).
- fail_count  output  5  mismatches in the current/last sweep, 0..16.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_idx  output  4  index of the first mismatching vector.
- observed_mask  output  16  captured F values; bit k = f_in sampled for vector k.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start:
  - Clear fail_count, first_fail_valid, first_fail_idx and observed_mask.
  - Set idx=0 and settle_cnt=0; go to SETTLE.
- SETTLE:
  - Increment settle_cnt each cycle.
  - When settle_cnt == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - Write f_in into observed_mask[idx].
  - If f_in != MINTERM_MASK[idx]: increment fail_count. If first_fail_valid == 0, also set first_fail_idx=idx and first_fail_valid=1.
  - If idx == 15, go to DONE. Otherwise increment idx, clear settle_cnt and go to SETTLE.
- vec_out = idx in SETTLE and SAMPLE; 4'b0000 in IDLE and DONE.
- start while busy is ignored; no restart, no counter disturbance.
- idx never wraps inside a sweep; termination is only via the idx==15 check.
- fail_count is 5 bits wide so that 16 mismatches do not overflow it.
- Result outputs hold their last values in DONE and are cleared only by the next accepted start or by rst.

## Timing
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_idx=0, observed_mask=0.
- Reset mid-sweep forces all reset values immediately (asynchronously); no partial results are retained.
- Edge 0 is the rising edge that samples start=1. From that edge:
  - vec_out=0 is driven.
  - Vector k is sampled at edge (k+1)*(SETTLE_CYCLES+1).
  - done rises after edge 16*(SETTLE_CYCLES+1), which is edge 48 at the default setting.
- busy is high from edge 0 up to the edge at which done rises, and is never high together with done.
- All outputs are registered; there are no combinational paths from f_in or start to any output.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, SETTLE, SAMPLE, DONE);
  - DEFAULT_MINTERM_MASK = 16'hDF03;
  - VEC_W = 4, NUM_VEC = 16, CNT_W = 5.
- One sub-module, settle_timer: a clear/enable counter that emits an expire pulse at SETTLE_CYCLES-1.
- The FSM, compare logic and result registers live in the top level.
- The function block itself is instantiated only in the bench, not inside this block.

## Test plan
- Ideal function connected, start at edge 0 -> done at edge 48, pass=1, fail_count=0, observed_mask=16'hDF03, first_fail_valid=0.
- f_in forced 0 while vec_out=12 -> fail_count=1, first_fail_idx=12, observed_mask=16'hCF03, pass=0.
- f_in stuck at 1 -> fail_count=7, first_fail_idx=2, observed_mask=16'hFFFF.
- rst asserted at edge 20 mid-sweep -> all outputs at reset values immediately; a new start afterwards gives done at 48 edges after it, pass=1.
- start re-pulsed at edge 10 while busy -> ignored, done still at edge 48; a start in DONE clears results and restarts.
- SETTLE_CYCLES=1 with the ideal function -> vector k sampled at edge 2(k+1), done at edge 32, pass=1.
